// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode definitions: opcodes, the NOP encoding and fetch states.
package fetch_unit_pkg;

  localparam logic [4:0]  OP_HALT   = 5'b00000;
  localparam logic [4:0]  OP_NOP    = 5'b00001;
  localparam logic [15:0] INSTR_NOP = 16'h0800;

  typedef enum logic [1:0] {
    FS_IDLE   = 2'd0,
    FS_FETCH  = 2'd1,
    FS_HALTED = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter with load / increment-by-2 / hold; bit 0 is always cleared.
module fetch_pc_reg #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_pc,
  input  logic        inc,
  output logic [15:0] pc,
  output logic [15:0] pc_plus2
);

  logic [15:0] pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pc_q <= RESET_PC & 16'hFFFE;
    else if (load)
      pc_q <= load_pc & 16'hFFFE;
    else if (inc)
      pc_q <= pc_q + 16'd2;
  end

  assign pc       = pc_q;
  assign pc_plus2 = pc_q + 16'd2;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem handshake, decode back-pressure, redirect, HALT.
// Optional macro FETCH_ALIGN_CHECK_EN: odd redirect target sets sticky err and halts.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = INSTR_NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instr,
  output logic        instr_valid,
  output logic [15:0] pc_plus2,
  output logic        halted,
  output logic        err
);

  fetch_state_e state_q, state_n;
  logic [15:0]  instr_q, instr_n;
  logic         valid_q, valid_n;
  logic [15:0]  pp2_q, pp2_n;
  logic [15:0]  pc, pc_inc_val;
  logic         pc_load, pc_inc;
  logic         capture;
  logic         align_fault;

  fetch_pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst      (rst),
    .load     (pc_load),
    .load_pc  (redirect_pc),
    .inc      (pc_inc),
    .pc       (pc),
    .pc_plus2 (pc_inc_val)
  );

`ifdef FETCH_ALIGN_CHECK_EN
  logic err_q;

  assign align_fault = redirect_en && redirect_pc[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_q <= 1'b0;
    else if (align_fault)
      err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign align_fault = 1'b0;
  assign err         = 1'b0;
`endif

  // Redirect suppresses the request, so a same-cycle response is never captured.
  assign imem_req  = (state_q == FS_FETCH) && !(valid_q && stall) && !redirect_en;
  assign imem_addr = pc;
  assign capture   = imem_req && imem_ready;

  always_comb begin
    state_n = state_q;
    instr_n = instr_q;
    valid_n = valid_q;
    pp2_n   = pp2_q;
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    if (redirect_en) begin
      pc_load = 1'b1;
      instr_n = NOP_INSTR;
      valid_n = 1'b0;
      state_n = align_fault ? FS_HALTED : FS_FETCH;
    end else begin
      if (capture) begin
        instr_n = imem_rdata;
        valid_n = 1'b1;
        pp2_n   = pc_inc_val;
        pc_inc  = 1'b1;
        if (imem_rdata[15:11] == OP_HALT)
          state_n = FS_HALTED;
      end else if (!stall) begin
        instr_n = NOP_INSTR;
        valid_n = 1'b0;
      end
      if (state_q == FS_IDLE)
        state_n = FS_FETCH;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FS_IDLE;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      pp2_q   <= '0;
    end else begin
      state_q <= state_n;
      instr_q <= instr_n;
      valid_q <= valid_n;
      pp2_q   <= pp2_n;
    end
  end

  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc_plus2    = pp2_q;
  assign halted      = (state_q == FS_HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a zero-wait-state style instruction memory model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_en;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_rdata;
  logic [15:0] instr;
  logic        instr_valid;
  logic [15:0] pc_plus2;
  logic        halted;
  logic        err;

  logic [15:0] mem [16];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  always_comb imem_rdata = mem[imem_addr[4:1]];

  fetch_unit #(
    .RESET_PC  (16'h0000),
    .NOP_INSTR (16'h0800)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc_plus2    (pc_plus2),
    .halted      (halted),
    .err         (err)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [15:0] e_instr, input logic e_valid,
                         input logic [15:0] e_pp2, input logic e_req, input logic [15:0] e_addr,
                         input logic e_halted);
    #1;
    check({tag, ".instr"},  instr,       e_instr);
    check({tag, ".valid"},  instr_valid, 16'(e_valid));
    check({tag, ".pp2"},    pc_plus2,    e_pp2);
    check({tag, ".req"},    imem_req,    16'(e_req));
    check({tag, ".addr"},   imem_addr,   e_addr);
    check({tag, ".halted"}, halted,      16'(e_halted));
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "timeout");
  end

  initial begin
    for (int unsigned i = 0; i < 16; i++) mem[i] = 16'h0800;
    mem[0]  = 16'h4001;
    mem[1]  = 16'h4802;
    mem[2]  = 16'h0800;
    mem[3]  = 16'h0000;
    mem[8]  = 16'h5010;
    mem[9]  = 16'h5012;
    mem[15] = 16'h6FFE;

    rst = 1'b1; stall = 1'b0; redirect_en = 1'b0; redirect_pc = '0; imem_ready = 1'b1;
    #1;
    chk_out("rst", 16'h0800, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    check("rst.err", err, 16'h0000);
    step();
    chk_out("rst_edge", 16'h0800, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);

    rst = 1'b0;
    chk_out("idle", 16'h0800, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    step();
    chk_out("fetch0", 16'h0800, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0);
    step();
    chk_out("cap0", 16'h4001, 1'b1, 16'h0002, 1'b1, 16'h0002, 1'b0);

    // memory not ready for two cycles at addr 2
    imem_ready = 1'b0;
    step();
    chk_out("wait1", 16'h0800, 1'b0, 16'h0002, 1'b1, 16'h0002, 1'b0);
    step();
    chk_out("wait2", 16'h0800, 1'b0, 16'h0002, 1'b1, 16'h0002, 1'b0);
    imem_ready = 1'b1;
    step();
    chk_out("cap2", 16'h4802, 1'b1, 16'h0004, 1'b1, 16'h0004, 1'b0);

    // decode stall holds 0x4802
    stall = 1'b1;
    chk_out("stall0", 16'h4802, 1'b1, 16'h0004, 1'b0, 16'h0004, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("stall", 16'h4802, 1'b1, 16'h0004, 1'b0, 16'h0004, 1'b0);
    end
    stall = 1'b0;
    chk_out("release", 16'h4802, 1'b1, 16'h0004, 1'b1, 16'h0004, 1'b0);
    step();
    chk_out("cap4", 16'h0800, 1'b1, 16'h0006, 1'b1, 16'h0006, 1'b0);

    // HALT at addr 6
    step();
    chk_out("halt", 16'h0000, 1'b1, 16'h0008, 1'b0, 16'h0008, 1'b1);
    stall = 1'b1;
    step();
    chk_out("halt_stall", 16'h0000, 1'b1, 16'h0008, 1'b0, 16'h0008, 1'b1);
    stall = 1'b0;
    step();
    chk_out("halt_idle", 16'h0800, 1'b0, 16'h0008, 1'b0, 16'h0008, 1'b1);
    step();
    chk_out("halt_idle2", 16'h0800, 1'b0, 16'h0008, 1'b0, 16'h0008, 1'b1);

    redirect_en = 1'b1; redirect_pc = 16'h0010;
    chk_out("redir_h", 16'h0800, 1'b0, 16'h0008, 1'b0, 16'h0008, 1'b1);
    step();
    redirect_en = 1'b0;
    chk_out("resume", 16'h0800, 1'b0, 16'h0008, 1'b1, 16'h0010, 1'b0);
    step();
    chk_out("cap10", 16'h5010, 1'b1, 16'h0012, 1'b1, 16'h0012, 1'b0);

    // redirect under stall with a would-be capture at 0x12
    stall = 1'b1; redirect_en = 1'b1; redirect_pc = 16'h0100;
    chk_out("redir_st", 16'h5010, 1'b1, 16'h0012, 1'b0, 16'h0012, 1'b0);
    step();
    stall = 1'b0; redirect_en = 1'b0;
    chk_out("flushed", 16'h0800, 1'b0, 16'h0012, 1'b1, 16'h0100, 1'b0);
    step();
    chk_out("cap100", 16'h4001, 1'b1, 16'h0102, 1'b1, 16'h0102, 1'b0);

    // PC wrap at 0xFFFE
    redirect_en = 1'b1; redirect_pc = 16'hFFFE;
    step();
    redirect_en = 1'b0;
    chk_out("at_fffe", 16'h0800, 1'b0, 16'h0102, 1'b1, 16'hFFFE, 1'b0);
    step();
    chk_out("wrap", 16'h6FFE, 1'b1, 16'h0000, 1'b1, 16'h0000, 1'b0);

    // odd redirect target
    redirect_en = 1'b1; redirect_pc = 16'h0011;
    step();
    redirect_en = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    chk_out("misalign", 16'h0800, 1'b0, 16'h0000, 1'b0, 16'h0010, 1'b1);
    check("misalign.err", err, 16'h0001);
    step();
    check("err_sticky", err, 16'h0001);
    check("err_halted", halted, 16'h0001);
`else
    chk_out("misalign", 16'h0800, 1'b0, 16'h0000, 1'b1, 16'h0010, 1'b0);
    check("misalign.err", err, 16'h0000);
    step();
    chk_out("cap10b", 16'h5010, 1'b1, 16'h0012, 1'b1, 16'h0012, 1'b0);
    check("err_zero", err, 16'h0000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the decode/control stage.
- Holds the PC and issues requests to the instruction memory over a req/ready handshake.
- Registers the returned 16-bit instruction, whose [15:11] is the opcode, and presents it with pc_plus2 to decode.
- Handles decode back-pressure, branch/jump redirects and HALT detection.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'h0800, instruction driven while instr_valid=0 (opcode 5'b00001, NOP).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  decode cannot accept; hold the current instruction
- redirect_en  in  1  branch/jump taken; load redirect_pc and flush
- redirect_pc  in  16  redirect target
- imem_req  out  1  fetch request, address valid
- imem_addr  out  16  fetch address (= pc)
- imem_ready  in  1  same-cycle response; imem_rdata valid when imem_req&&imem_ready
- imem_rdata  in  16  fetched instruction
- instr  out  16  registered instruction to decode
- instr_valid  out  1  instr is a real instruction
- pc_plus2  out  16  address of instr + 2
- halted  out  1  fetch stopped on HALT
- err  out  1  sticky misaligned-redirect error

Behaviour:
- Reset (async, rst=1), all values immediate:
  - pc=RESET_PC, state=IDLE
  - instr=NOP_INSTR, instr_valid=0, pc_plus2=0
  - imem_req=0, halted=0, err=0
- States: IDLE, FETCH, HALTED.
- IDLE:
  - One cycle after rst deasserts, imem_req=0.
  - Moves to FETCH unconditionally, or to pc=redirect_pc if redirect_en.
- FETCH:
  - imem_req = !(instr_valid && stall) && !redirect_en.
  - imem_addr = pc at all times (combinational).
  - capture = imem_req && imem_ready.
- On capture:
  - instr<=imem_rdata, instr_valid<=1, pc_plus2<=pc+2, pc<=pc+2.
  - 16-bit wrap: 16'hFFFE -> 16'h0000.
  - Latency: memory response to instr valid at decode = 1 cycle.
- No capture and !stall: instr<=NOP_INSTR, instr_valid<=0 (bubble).
- No capture and stall: instr, instr_valid, pc_plus2 hold.
- HALT detection: capture with imem_rdata[15:11]==5'b00000:
  - HALT is delivered valid once, then state<=HALTED.
  - No further requests are issued.
- HALTED:
  - halted=1, imem_req=0.
  - HALT instr stays valid while stall; becomes NOP/invalid when !stall.
- redirect_en (any state except reset), highest priority:
  - pc<=redirect_pc; instr<=NOP_INSTR, instr_valid<=0, even if stall=1.
  - Any same-cycle capture is discarded: imem_req is forced 0.
  - State<=FETCH, halted<=0. This covers a wrong-path HALT fetched behind an older branch.
- Back-pressure: no request while a valid instr is stalled, so no instruction is ever dropped or duplicated.
- rst during a pending memory wait: the request drops immediately and the memory must tolerate withdrawal.
- pc[0] is always 0 after reset; the RESET_PC bit 0 is ignored.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined: redirect_en with redirect_pc[0]=1 behaves as follows:
  - err<=1 (sticky until rst) and state<=HALTED, halted=1.
  - pc<=redirect_pc&16'hFFFE; instr_valid<=0.
- Undefined:
  - redirect_pc[0] is silently forced to 0 and fetch continues normally.
  - err is tied 0.

Decomposition:
- Shared package/include holds:
  - opcode constants OP_HALT=5'b00000, OP_NOP=5'b00001
  - INSTR_NOP=16'h0800
  - fetch state encodings FS_IDLE/FS_FETCH/FS_HALTED (2 bits)
  - these also serve the decode/control stage.
- One natural sub-module: fetch_pc_reg.
  - 16-bit async-reset PC register with load (redirect) / increment-by-2 (capture) / hold select.
  - Exports pc and pc+2.

Test Plan:
1. Reset, memory always ready, instrs 0x4001,0x4802,0x0800 at 0,2,4 -> imem_addr 0,2,4,6 on consecutive cycles; instr_valid high from 2nd FETCH cycle; pc_plus2=2,4,6.
2. stall=1 for 3 cycles while instr=0x4802 valid -> imem_req=0, instr/pc_plus2 held; on release the next fetch is addr 4, with no skip or duplicate.
3. imem_ready low 2 cycles at addr 2 -> imem_req held with addr 2; instr_valid=0 bubble; capture on 3rd cycle.
4. redirect_en with redirect_pc=0x0100 while stall=1 and a capture is pending -> instr_valid=0 next cycle, next imem_addr=0x0100, stale data not delivered.
5. HALT (0x0000) at addr 6 -> delivered valid once; halted=1; imem_req stays 0; later redirect to 0x0010 clears halted and resumes fetch.
6. pc=0xFFFE fetch -> pc wraps to 0x0000. With FETCH_ALIGN_CHECK_EN, redirect_pc=0x0011 -> err=1, halted=1; without the macro, fetch proceeds at 0x0010 and err=0.
